rf_access_ctrl: RTL

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

---
 rtl/rf_access_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl
// Shares the single register-file write port between core writeback, the load
// unit and the debug port, and lets debug borrow the rs1 read port for a
// register read by briefly stalling the core. Requesters that keep losing
// arbitration get a bounded wait: their counter saturating forces a core
// stall, and while stalled the starved requester owns the write port.
module rf_access_ctrl #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rstB,

    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,

    input  logic [4:0]  coreRs1Addr,
    input  logic [4:0]  coreRs2Addr,
    output logic        coreStall,

    input  logic        ldValid,
    input  logic [4:0]  ldAddr,
    input  logic [31:0] ldData,
    output logic        ldReady,

    input  logic        dbgValid,
    input  logic        dbgWr,
    input  logic [4:0]  dbgAddr,
    input  logic [31:0] dbgWdata,
    output logic        dbgReady,

    output logic        dbgRvalid,
    output logic [31:0] dbgRdata,
    input  logic        dbgRready,

    output logic        rfWrEn,
    output logic [4:0]  rfWrAddr,
    output logic [31:0] rfWrData,

    output logic [4:0]  rfRs1Addr,
    output logic [4:0]  rfRs2Addr,
    input  logic [31:0] rfR1
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_STALL = 2'd1,
        RD_CAP   = 2'd2,
        RD_RESP  = 2'd3
    } rd_state_t;

    rd_state_t     rdState;
    logic [4:0]    rdAddr;
    logic [CW-1:0] ldWait;
    logic [CW-1:0] dbgWait;
    logic [CW-1:0] ldWaitNext;
    logic [CW-1:0] dbgWaitNext;

    logic dbgWrReq;
    logic ldStarved;
    logic dbgStarved;
    logic wbGrant;
    logic ldGrant;
    logic dbgWrGrant;
    logic rdAccept;

    // Pick at most one writer per cycle; a starved requester beats writeback,
    // and debug writes wait while a debug read is in flight.
    always_comb begin
        wbGrant    = 1'b0;
        ldGrant    = 1'b0;
        dbgWrGrant = 1'b0;
        dbgWrReq   = dbgValid && dbgWr;
        ldStarved  = ldValid && (ldWait == WAIT_MAX);
        dbgStarved = dbgWrReq && (dbgWait == WAIT_MAX) && (rdState == IDLE);
        if (rstB) begin
            if (ldStarved) begin
                ldGrant = 1'b1;
            end else if (dbgStarved) begin
                dbgWrGrant = 1'b1;
            end else if (wbEn) begin
                wbGrant = 1'b1;
            end else if (ldValid) begin
                ldGrant = 1'b1;
            end else if (dbgWrReq && (rdState == IDLE)) begin
                dbgWrGrant = 1'b1;
            end
        end
    end

    // Drive the write port from the winner; x0 handshakes but never writes,
    // and the port idles at zero when nobody wins.
    always_comb begin
        rfWrEn   = 1'b0;
        rfWrAddr = 5'd0;
        rfWrData = 32'd0;
        if (wbGrant) begin
            rfWrEn   = (wbAddr != 5'd0);
            rfWrAddr = wbAddr;
            rfWrData = wbData;
        end else if (ldGrant) begin
            rfWrEn   = (ldAddr != 5'd0);
            rfWrAddr = ldAddr;
            rfWrData = ldData;
        end else if (dbgWrGrant) begin
            rfWrEn   = (dbgAddr != 5'd0);
            rfWrAddr = dbgAddr;
            rfWrData = dbgWdata;
        end
    end

    // A debug read is taken only from IDLE and never alongside a debug write
    // grant; the read port is borrowed only during RD_STALL.
    always_comb begin
        rdAccept  = rstB && (rdState == IDLE) && dbgValid && !dbgWr && !dbgWrGrant;
        ldReady   = ldGrant;
        dbgReady  = dbgWrGrant || rdAccept;
        rfRs1Addr = (rdState == RD_STALL) ? rdAddr : coreRs1Addr;
        rfRs2Addr = coreRs2Addr;
    end

    // Wait counters count losing cycles, saturate, and clear on grant or drop.
    always_comb begin
        if (!ldValid || ldGrant) begin
            ldWaitNext = '0;
        end else if (ldWait != WAIT_MAX) begin
            ldWaitNext = ldWait + 1'b1;
        end else begin
            ldWaitNext = ldWait;
        end
        if (!dbgWrReq || dbgWrGrant) begin
            dbgWaitNext = '0;
        end else if (dbgWait != WAIT_MAX) begin
            dbgWaitNext = dbgWait + 1'b1;
        end else begin
            dbgWaitNext = dbgWait;
        end
    end

    // Register the wait counters and the core stall, which covers the two
    // read cycles that borrow the read port and any pending starvation grant.
    always_ff @(posedge clk) begin
        if (!rstB) begin
            ldWait    <= '0;
            dbgWait   <= '0;
            coreStall <= 1'b0;
        end else begin
            ldWait    <= ldWaitNext;
            dbgWait   <= dbgWaitNext;
            coreStall <= rdAccept || (rdState == RD_STALL) ||
                         (ldWaitNext == WAIT_MAX) || (dbgWaitNext == WAIT_MAX);
        end
    end

    // Debug read sequencer: present the address, capture the data a cycle
    // later, then hold the response until the debugger takes it.
    always_ff @(posedge clk) begin
        if (!rstB) begin
            rdState   <= IDLE;
            rdAddr    <= 5'd0;
            dbgRvalid <= 1'b0;
            dbgRdata  <= 32'd0;
        end else begin
            case (rdState)
                IDLE: begin
                    if (rdAccept) begin
                        rdAddr  <= dbgAddr;
                        rdState <= RD_STALL;
                    end
                end
                RD_STALL: begin
                    rdState <= RD_CAP;
                end
                RD_CAP: begin
                    dbgRdata  <= rfR1;
                    dbgRvalid <= 1'b1;
                    rdState   <= RD_RESP;
                end
                RD_RESP: begin
                    if (dbgRready) begin
                        dbgRvalid <= 1'b0;
                        rdState   <= IDLE;
                    end
                end
                default: begin
                    dbgRvalid <= 1'b0;
                    rdState   <= IDLE;
                end
            endcase
        end
    end

endmodule
